// File: rtl/elevator_scheduler.sv
// elevator_scheduler: single-car, four-floor scheduler with latched hall and car calls.
// Latency: a call pulse shows in pend_up/pend_dn one cycle after it is sampled; IDLE acts on it the cycle after that.
// Backpressure: none; calls are latched. Optional macro DOOR_REOPEN_EN lets door_block hold the door open.
module elevator_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hall_up,
  input  logic [3:0] hall_dn,
  input  logic [3:0] car_call,
  input  logic       door_block,
  output logic [1:0] cur_floor,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       door_open,
  output logic       dir_up,
  output logic [3:0] pend_up,
  output logic [3:0] pend_dn
);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE_UP = 2'd1, MOVE_DN = 2'd2, DOOR = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [1:0]      floor_q, floor_d;
  logic            dir_q, dir_d;
  logic [3:0]      pu_q, pd_q;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;

  logic [3:0] hu, hd, calls, set_u, set_d, clr_u, clr_d;
  logic [1:0] nxt_up, nxt_dn;
  logic       door_hit, hold_door;

  function automatic logic any_above(input logic [3:0] c, input logic [1:0] f);
    logic [3:0] m;
    m = 4'b1110 << f;
    return |(c & m);
  endfunction

  function automatic logic any_below(input logic [3:0] c, input logic [1:0] f);
    logic [3:0] m;
    m = 4'b0111 >> (2'd3 - f);
    return |(c & m);
  endfunction

  // Top floor has no up button, bottom floor has no down button.
  assign hu     = hall_up & 4'b0111;
  assign hd     = hall_dn & 4'b1110;
  assign calls  = pu_q | pd_q;
  assign nxt_up = floor_q + 2'd1;
  assign nxt_dn = floor_q - 2'd1;

  // A same-direction call at the open floor just keeps the door open instead of being queued.
  assign door_hit = (state_q == DOOR) &&
                    ((dir_q ? hu[floor_q] : hd[floor_q]) || car_call[floor_q]);

`ifdef DOOR_REOPEN_EN
  assign hold_door = door_hit || door_block;
`else
  logic door_block_unused;
  assign door_block_unused = door_block;
  assign hold_door = door_hit;
`endif

  // Sort incoming pulses into up/down pending sets relative to the car position.
  always_comb begin
    set_u = hu;
    set_d = hd;
    for (int i = 0; i < 4; i++) begin
      if (car_call[i]) begin
        if (2'(i) > floor_q)      set_u[i] = 1'b1;
        else if (2'(i) < floor_q) set_d[i] = 1'b1;
        else if (dir_q)           set_u[i] = 1'b1;
        else                      set_d[i] = 1'b1;
      end
    end
    if (door_hit) begin
      if (dir_q) set_u[floor_q] = 1'b0;
      else       set_d[floor_q] = 1'b0;
    end
  end

  // Next-state, counters and which pending calls get served (cleared).
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    clr_u   = 4'b0000;
    clr_d   = 4'b0000;
    case (state_q)
      IDLE: begin
        if (calls[floor_q]) begin
          state_d        = DOOR;
          dcnt_d         = '0;
          clr_u[floor_q] = 1'b1;
          clr_d[floor_q] = 1'b1;
        end else if (calls != 4'b0000) begin
          tcnt_d = '0;
          if (dir_q && any_above(calls, floor_q)) begin
            state_d = MOVE_UP;
          end else if (any_below(calls, floor_q)) begin
            state_d = MOVE_DN;
            dir_d   = 1'b0;
          end else begin
            state_d = MOVE_UP;
            dir_d   = 1'b1;
          end
        end
      end
      MOVE_UP: begin
        if (tcnt_q == T_LAST) begin
          floor_d = nxt_up;
          tcnt_d  = '0;
          if (pu_q[nxt_up] || !any_above(calls, nxt_up)) begin
            state_d       = DOOR;
            dcnt_d        = '0;
            clr_u[nxt_up] = 1'b1;
            if (!any_above(calls, nxt_up)) begin
              dir_d         = 1'b0;
              clr_d[nxt_up] = 1'b1;
            end
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      MOVE_DN: begin
        if (tcnt_q == T_LAST) begin
          floor_d = nxt_dn;
          tcnt_d  = '0;
          if (pd_q[nxt_dn] || !any_below(calls, nxt_dn)) begin
            state_d       = DOOR;
            dcnt_d        = '0;
            clr_d[nxt_dn] = 1'b1;
            if (!any_below(calls, nxt_dn)) begin
              dir_d         = 1'b1;
              clr_u[nxt_dn] = 1'b1;
            end
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DOOR: begin
        if (hold_door) begin
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; a clear beats a set on the same pending bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      floor_q <= 2'd0;
      dir_q   <= 1'b1;
      pu_q    <= 4'b0000;
      pd_q    <= 4'b0000;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pu_q    <= (pu_q | set_u) & ~clr_u;
      pd_q    <= (pd_q | set_d) & ~clr_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign cur_floor = floor_q;
  assign motor_up  = (state_q == MOVE_UP);
  assign motor_dn  = (state_q == MOVE_DN);
  assign door_open = (state_q == DOOR);
  assign dir_up    = dir_q;
  assign pend_up   = pu_q;
  assign pend_dn   = pd_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random call traffic.
// Every cycle the DUT outputs are compared with a countdown-timer reference model.
// Outputs are sampled 1 time unit after the rising edge; inputs change at that point.
module tb_elevator_scheduler;
  localparam int TC = 8;
  localparam int DC = 6;
`ifdef DOOR_REOPEN_EN
  localparam bit REOPEN = 1'b1;
`else
  localparam bit REOPEN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] hall_up, hall_dn, car_call;
  logic       door_block;
  logic [1:0] cur_floor;
  logic       motor_up, motor_dn, door_open, dir_up;
  logic [3:0] pend_up, pend_dn;

  int n_checks = 0;
  int n_fail   = 0;

  elevator_scheduler #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .hall_up(hall_up), .hall_dn(hall_dn),
    .car_call(car_call), .door_block(door_block), .cur_floor(cur_floor),
    .motor_up(motor_up), .motor_dn(motor_dn), .door_open(door_open),
    .dir_up(dir_up), .pend_up(pend_up), .pend_dn(pend_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: car activity and remaining-cycle timers.
  localparam int P_IDLE = 0, P_UP = 1, P_DN = 2, P_DOOR = 3;
  int       m_phase, m_floor, m_tleft, m_dleft;
  bit       m_dir;
  bit [3:0] m_pu, m_pd;

  function automatic bit beyond(input bit [3:0] pu, input bit [3:0] pd, input int f, input bit up);
    for (int i = 0; i < 4; i++)
      if ((up ? (i > f) : (i < f)) && (pu[i] || pd[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit [3:0] hu_in, input bit [3:0] hd_in,
                            input bit [3:0] cc_in, input bit blk, input bit rst);
    bit [3:0] su, sd, cu, cd;
    bit restart, up, ahead, here;
    if (rst) begin
      m_phase = P_IDLE; m_floor = 0; m_dir = 1'b1;
      m_pu = 4'b0; m_pd = 4'b0; m_tleft = 0; m_dleft = 0;
      return;
    end
    su = hu_in; su[3] = 1'b0;
    sd = hd_in; sd[0] = 1'b0;
    cu = 4'b0;  cd = 4'b0;
    for (int f = 0; f < 4; f++)
      if (cc_in[f]) begin
        if (f > m_floor) su[f] = 1'b1;
        else if (f < m_floor) sd[f] = 1'b1;
        else if (m_dir) su[f] = 1'b1;
        else sd[f] = 1'b1;
      end
    restart = (m_phase == P_DOOR) && (m_dir ? su[m_floor] : sd[m_floor]);
    if (restart) begin
      if (m_dir) su[m_floor] = 1'b0;
      else       sd[m_floor] = 1'b0;
    end
    case (m_phase)
      P_IDLE: begin
        if (m_pu[m_floor] || m_pd[m_floor]) begin
          m_phase = P_DOOR; m_dleft = DC;
          cu[m_floor] = 1'b1; cd[m_floor] = 1'b1;
        end else if ((m_pu | m_pd) != 4'b0) begin
          m_tleft = TC;
          if (m_dir && beyond(m_pu, m_pd, m_floor, 1'b1)) m_phase = P_UP;
          else if (beyond(m_pu, m_pd, m_floor, 1'b0)) begin m_phase = P_DN; m_dir = 1'b0; end
          else begin m_phase = P_UP; m_dir = 1'b1; end
        end
      end
      P_UP, P_DN: begin
        up = (m_phase == P_UP);
        m_tleft--;
        if (m_tleft == 0) begin
          m_floor = m_floor + (up ? 1 : -1);
          ahead = beyond(m_pu, m_pd, m_floor, up);
          here  = up ? m_pu[m_floor] : m_pd[m_floor];
          if (here || !ahead) begin
            m_phase = P_DOOR; m_dleft = DC;
            if (up) cu[m_floor] = 1'b1; else cd[m_floor] = 1'b1;
            if (!ahead) begin
              m_dir = !up;
              if (up) cd[m_floor] = 1'b1; else cu[m_floor] = 1'b1;
            end
          end else begin
            m_tleft = TC;
          end
        end
      end
      default: begin
        if (restart || (REOPEN && blk)) m_dleft = DC;
        else begin
          m_dleft--;
          if (m_dleft == 0) m_phase = P_IDLE;
        end
      end
    endcase
    m_pu = (m_pu | su) & ~cu;
    m_pd = (m_pd | sd) & ~cd;
  endtask

  // One clock: drive inputs, step the model, compare every output.
  task automatic cyc(input logic [3:0] hu, input logic [3:0] hd, input logic [3:0] cc,
                     input logic blk, input logic rst);
    hall_up = hu; hall_dn = hd; car_call = cc; door_block = blk; reset = rst;
    @(posedge clk);
    #1;
    model_step(hu, hd, cc, blk, rst);
    check("cur_floor", 32'(cur_floor), 32'(m_floor));
    check("motor_door", 32'({motor_up, motor_dn, door_open}),
          32'({m_phase == P_UP, m_phase == P_DN, m_phase == P_DOOR}));
    check("dir_up", 32'(dir_up), 32'(m_dir));
    check("pending", 32'({pend_up, pend_dn}), 32'({m_pu, m_pd}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0, 4'b0, 4'b0, 1'b0, 1'b0);
  endtask

  // what: 0 door opens, 1 door closed, 2 car moving up past floor 1.
  task automatic wait_until(input int what, input int max, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      idle(1);
      case (what)
        0:       hit = (door_open === 1'b1);
        1:       hit = (door_open === 1'b0);
        default: hit = (cur_floor === 2'd1) && (motor_up === 1'b1);
      endcase
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    cyc(4'b0, 4'b0, 4'b0, 1'b0, 1'b1);
  endtask

  int n_up, n_door, exp_door;

  initial begin
    hall_up = 4'b0; hall_dn = 4'b0; car_call = 4'b0; door_block = 1'b0; reset = 1'b1;
    do_reset();
    check("rst_outputs", 32'({cur_floor, motor_up, motor_dn, door_open, dir_up}), 32'b000001);
    check("rst_pending", 32'({pend_up, pend_dn}), 32'd0);

    // Floor 0 to 3 on a single car call.
    cyc(4'b0, 4'b0, 4'b1000, 1'b0, 1'b0);
    n_up = 0; n_door = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (motor_up) n_up++;
      if (door_open) n_door++;
    end
    check("s1_up_cycles", 32'(n_up), 32'd24);
    check("s1_door_cycles", 32'(n_door), 32'd6);
    check("s1_floor", 32'(cur_floor), 32'd3);
    check("s1_idle", 32'({motor_up, motor_dn, door_open}), 32'd0);
    check("s1_dir", 32'(dir_up), 32'd0);

    // Hall down at 2 plus car call 1: stop at 1, then 2 with direction flip.
    do_reset();
    cyc(4'b0, 4'b0100, 4'b0010, 1'b0, 1'b0);
    wait_until(0, 60, "s2_door1");
    check("s2_floor1", 32'(cur_floor), 32'd1);
    check("s2_dir1", 32'(dir_up), 32'd1);
    wait_until(1, 20, "s2_close1");
    wait_until(0, 60, "s2_door2");
    check("s2_floor2", 32'(cur_floor), 32'd2);
    check("s2_dir2", 32'(dir_up), 32'd0);
    wait_until(1, 20, "s2_close2");
    check("s2_pending", 32'({pend_up, pend_dn}), 32'd0);

    // Hall up at 2 while between 1 and 2: stop at 2.
    do_reset();
    cyc(4'b0, 4'b0, 4'b1000, 1'b0, 1'b0);
    wait_until(2, 40, "s3a_at1");
    cyc(4'b0100, 4'b0, 4'b0, 1'b0, 1'b0);
    wait_until(0, 40, "s3a_door");
    check("s3a_floor", 32'(cur_floor), 32'd2);
    wait_until(1, 20, "s3a_close");
    wait_until(0, 40, "s3a_door3");
    check("s3a_floor3", 32'(cur_floor), 32'd3);
    wait_until(1, 20, "s3a_close3");

    // Hall down at 2 instead: passes 2, stops at 3, then returns to 2.
    do_reset();
    cyc(4'b0, 4'b0, 4'b1000, 1'b0, 1'b0);
    wait_until(2, 40, "s3b_at1");
    cyc(4'b0, 4'b0100, 4'b0, 1'b0, 1'b0);
    wait_until(0, 40, "s3b_door");
    check("s3b_floor", 32'(cur_floor), 32'd3);
    check("s3b_pend_dn", 32'(pend_dn), 32'b0100);
    wait_until(1, 20, "s3b_close");
    wait_until(0, 40, "s3b_door2");
    check("s3b_floor2", 32'(cur_floor), 32'd2);
    wait_until(1, 20, "s3b_close2");

    // Same-direction hall call at the open floor restarts the door.
    do_reset();
    cyc(4'b0, 4'b0, 4'b1010, 1'b0, 1'b0);
    wait_until(0, 40, "s4_door");
    check("s4_floor", 32'(cur_floor), 32'd1);
    check("s4_dir", 32'(dir_up), 32'd1);
    idle(2);
    cyc(4'b0010, 4'b0, 4'b0, 1'b0, 1'b0);
    n_door = door_open ? 1 : 0;
    check("s4_pend_up1", 32'(pend_up[1]), 32'd0);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (i == 0) check("s4_pend_up1_later", 32'(pend_up[1]), 32'd0);
      if (door_open) n_door++;
      else break;
    end
    check("s4_door_after_restart", 32'(n_door), 32'd6);
    wait_until(0, 60, "s4_door3");
    wait_until(1, 20, "s4_close3");

    // Reset mid-travel wins over a simultaneous call pulse.
    do_reset();
    cyc(4'b0, 4'b0, 4'b1000, 1'b0, 1'b0);
    wait_until(2, 40, "s5_at1");
    cyc(4'b0100, 4'b0, 4'b0, 1'b0, 1'b1);
    check("s5_outputs", 32'({cur_floor, motor_up, motor_dn, door_open, dir_up}), 32'b000001);
    check("s5_pending", 32'({pend_up, pend_dn}), 32'd0);
    idle(1);
    check("s5_discard", 32'({pend_up, pend_dn, motor_up}), 32'd0);

    // door_block held for 10 cycles.
    do_reset();
    cyc(4'b0, 4'b0, 4'b0001, 1'b0, 1'b0);
    wait_until(0, 10, "s6_door");
    n_door = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0, 4'b0, 4'b0, 1'b1, 1'b0);
      if (door_open) n_door++;
    end
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (door_open) n_door++;
      else break;
    end
    exp_door = REOPEN ? 16 : 6;
    check("s6_door_cycles", 32'(n_door), 32'(exp_door));

    // Random call traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rhu, rhd, rcc;
      rhu = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      rhd = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      rcc = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      cyc(rhu, rhd, rcc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 799) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 The block SHALL expose parameters, one per line:
 - TRAVEL_CYCLES, default 8, clock cycles to move one floor (min 2).
 - DOOR_CYCLES, default 6, clock cycles the door stays open (min 2).
REQ-002 The block SHALL expose ports, one per line:
 - clk  in  1  single clock, all logic on posedge.
 - reset  in  1  synchronous, active-high reset.
 - hall_up  in  4  hall up-call pulses, bit f = floor f; bit 3 ignored.
 - hall_dn  in  4  hall down-call pulses, bit f = floor f; bit 0 ignored.
 - car_call  in  4  in-car floor-button pulses, bit f = floor f.
 - door_block  in  1  door obstruction (active only with DOOR_REOPEN_EN).
 - cur_floor  out  2  current or last-passed floor.
 - motor_up  out  1  car moving up.
 - motor_dn  out  1  car moving down.
 - door_open  out  1  door open.
 - dir_up  out  1  travel direction, 1 = up, 0 = down.
 - pend_up  out  4  latched up-calls plus car calls above the car.
 - pend_dn  out  4  latched down-calls plus car calls below the car.
REQ-003 Clock and reset SHALL be one clock, reset synchronous and active-high, ports named clk and reset.

Function
REQ-004 FSM states SHALL be IDLE, MOVE_UP, MOVE_DN, DOOR; exactly one of motor_up/motor_dn/door_open SHALL be high outside IDLE, none in IDLE.
REQ-005 Call pulses SHALL be latched on the cycle they are sampled and appear in pend_up/pend_dn one cycle later; car_call[f] with f > cur_floor SHALL set pend_up[f], f < cur_floor SHALL set pend_dn[f].
REQ-006 In IDLE with no pending call, the state SHALL hold; with a call at cur_floor the state SHALL go to DOOR next cycle.
REQ-007 In IDLE otherwise: dir_up=1 and any call above -> MOVE_UP; else any call below -> MOVE_DN with dir_up=0; else -> MOVE_UP with dir_up=1.
REQ-008 In MOVE_UP/MOVE_DN the travel counter SHALL count TRAVEL_CYCLES; on terminal count cur_floor SHALL increment or decrement by 1 in that cycle.
REQ-009 At each arrival the car SHALL stop (go to DOOR) if there is a call at that floor in dir_up's direction or a car call there, or if no call lies further in dir_up's direction; otherwise it SHALL continue with the counter reloaded.
REQ-010 If the car stops at a floor with no call further ahead, dir_up SHALL flip, and the opposite-direction hall call at that floor SHALL be served.
REQ-011 cur_floor SHALL never exceed 3 or go below 0; arrival at floor 3 or 0 SHALL force a stop.
REQ-012 On entry to DOOR, the served calls at cur_floor SHALL be cleared; DOOR SHALL last DOOR_CYCLES, then go to IDLE.
REQ-013 A call at cur_floor in the served direction arriving while in DOOR SHALL restart the door counter and SHALL NOT be latched.
REQ-014 A call set and a clear for the same bit in the same cycle SHALL resolve as clear, except when REQ-013 applies.
REQ-015 Calls arriving while moving SHALL be latched normally; a call for the floor being approached SHALL be honoured at that arrival if it is in the served direction.

Reset
REQ-016 reset SHALL force, on the next clk edge: state IDLE, cur_floor=0, dir_up=1, all pending calls 0, both counters 0, motor_up=motor_dn=door_open=0.
REQ-017 reset SHALL take priority over all inputs, including mid-travel and mid-door; call pulses in the reset cycle SHALL be discarded.

Configuration
REQ-018 Macro DOOR_REOPEN_EN: when defined, door_block=1 in DOOR SHALL reload the door counter every cycle it is held; when undefined, door_block SHALL be ignored and the port kept.

Verification
REQ-019 The bench SHALL cover these scenarios (TRAVEL_CYCLES=8, DOOR_CYCLES=6):
 - Reset then car_call=4'b1000 -> motor_up for 24 cycles, cur_floor 0->3, door_open 6 cycles, then IDLE.
 - At floor 0: hall_dn[2] and car_call[1] together -> stop at 1, continue to 2, dir_up flips to 0 at floor 2.
 - Moving up between 1 and 2: hall_up[2] pulse -> stop at floor 2; hall_dn[2] pulse instead -> no stop if a call exists at 3.
 - In DOOR at floor 1 with dir_up=1: hall_up[1] pulse -> door counter restarts, pend_up[1] stays 0.
 - reset asserted mid-MOVE_UP at floor 1 -> next cycle cur_floor=0, outputs 0, pending 0.
 - DOOR_REOPEN_EN defined: door_block held for 10 cycles -> door_open for 10+6 cycles; undefined -> 6 cycles.
